// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle processor control unit.
// One instruction walks FETCH -> DECODE -> EXEC -> MEM -> WB over a shared
// instruction/data memory. Datapath strobes are decoded combinationally from
// the current state, opcode, zero flag and memory handshake, and are forced
// inactive while rst is high. Undefined opcodes park the FSM in ILLEGAL
// until reset.
module mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic        zero,
    input  logic        memReady,
    output logic        memRead,
    output logic        memWrite,
    output logic        iord,
    output logic        irWrite,
    output logic        pcWrite,
    output logic [1:0]  pcSrc,
    output logic        regWrite,
    output logic        regSel,
    output logic        selDM,
    output logic        imSel,
    output logic        selFunc,
    output logic [7:0]  funcCtrl,
    output logic        illegal,
    output logic [15:0] instCount,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXEC    = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        ILLEGAL = 3'd5
    } state_t;

    localparam logic [3:0] OP_LOAD    = 4'b0000;
    localparam logic [3:0] OP_STORE   = 4'b0001;
    localparam logic [3:0] OP_JUMP    = 4'b0010;
    localparam logic [3:0] OP_BRANCHZ = 4'b0100;
    localparam logic [3:0] OP_TYPEC   = 4'b1000;
    localparam logic [3:0] OP_ADDI    = 4'b1100;
    localparam logic [3:0] OP_SUBI    = 4'b1101;
    localparam logic [3:0] OP_ANDI    = 4'b1110;
    localparam logic [3:0] OP_ORI     = 4'b1111;

    localparam logic [7:0] FN_ADD = 8'b0000_0010;
    localparam logic [7:0] FN_SUB = 8'b0000_0100;
    localparam logic [7:0] FN_AND = 8'b0000_1000;
    localparam logic [7:0] FN_OR  = 8'b0001_0000;
    localparam logic [7:0] FN_NOP = 8'b0100_0000;

    localparam logic [1:0] PC_INC    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    state_t st;
    logic   retire;

    // True for every opcode the machine knows how to execute.
    function automatic logic op_defined(input logic [3:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_JUMP, OP_BRANCHZ, OP_TYPEC,
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    // I-type ALU instructions all share the 11xx prefix.
    function automatic logic op_itype(input logic [3:0] op);
        return (op[3:2] == 2'b11);
    endfunction

    // The low two opcode bits pick the ALU operation of an I-type instruction.
    function automatic logic [7:0] itype_func(input logic [3:0] op);
        case (op[1:0])
            2'b00:   return FN_ADD;
            2'b01:   return FN_SUB;
            2'b10:   return FN_AND;
            default: return FN_OR;
        endcase
    endfunction

    // Debug view of the state reads FETCH for as long as reset is held.
    assign state = rst ? FETCH : st;

    // Decode strobes and the retire pulse from the current state and inputs.
    always_comb begin
        memRead  = 1'b0;
        memWrite = 1'b0;
        iord     = 1'b0;
        irWrite  = 1'b0;
        pcWrite  = 1'b0;
        pcSrc    = PC_INC;
        regWrite = 1'b0;
        regSel   = 1'b0;
        selDM    = 1'b0;
        imSel    = 1'b0;
        selFunc  = 1'b0;
        funcCtrl = FN_NOP;
        illegal  = 1'b0;
        retire   = 1'b0;
        if (!rst) begin
            case (st)
                FETCH: begin
                    memRead = 1'b1;
                    iord    = 1'b0;
                    if (memReady) begin
                        irWrite = 1'b1;
                        pcWrite = 1'b1;
                        pcSrc   = PC_INC;
                    end
                end
                DECODE: begin
                    if (opcode == OP_JUMP) begin
                        pcWrite = 1'b1;
                        pcSrc   = PC_JUMP;
                        retire  = 1'b1;
                    end
                end
                EXEC: begin
                    if (opcode == OP_LOAD || opcode == OP_STORE) begin
                        funcCtrl = FN_ADD;
                        imSel    = 1'b1;
                    end else if (op_itype(opcode)) begin
                        funcCtrl = itype_func(opcode);
                        imSel    = 1'b1;
                    end else if (opcode == OP_TYPEC) begin
                        selFunc = 1'b1;
                    end else if (opcode == OP_BRANCHZ) begin
                        funcCtrl = FN_SUB;
                        retire   = 1'b1;
                        if (zero) begin
                            pcWrite = 1'b1;
                            pcSrc   = PC_BRANCH;
                        end
                    end
                end
                MEM: begin
                    iord     = 1'b1;
                    memRead  = (opcode == OP_LOAD);
                    memWrite = (opcode == OP_STORE);
                    retire   = memReady && (opcode == OP_STORE);
                end
                WB: begin
                    regWrite = 1'b1;
                    retire   = 1'b1;
                    if (opcode == OP_LOAD) begin
                        selDM = 1'b1;
                    end else if (opcode == OP_TYPEC) begin
                        regSel = 1'b1;
                    end else if (op_itype(opcode)) begin
                        imSel    = 1'b1;
                        funcCtrl = itype_func(opcode);
                    end
                end
                ILLEGAL: begin
                    illegal = 1'b1;
                end
                default: begin
                    illegal = 1'b0;
                end
            endcase
        end
    end

    // State register and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= FETCH;
            instCount <= '0;
        end else begin
            if (retire) begin
                instCount <= instCount + 16'd1;
            end
            case (st)
                FETCH: begin
                    if (memReady) st <= DECODE;
                end
                DECODE: begin
                    if (opcode == OP_JUMP)        st <= FETCH;
                    else if (!op_defined(opcode)) st <= ILLEGAL;
                    else                          st <= EXEC;
                end
                EXEC: begin
                    if (opcode == OP_LOAD || opcode == OP_STORE)       st <= MEM;
                    else if (opcode == OP_TYPEC || op_itype(opcode))   st <= WB;
                    else                                               st <= FETCH;
                end
                MEM: begin
                    if (memReady) st <= (opcode == OP_LOAD) ? WB : FETCH;
                end
                WB:      st <= FETCH;
                ILLEGAL: st <= ILLEGAL;
                default: st <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed bench for the multicycle control unit.
module tb_mc_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  opcode;
    logic        zero;
    logic        memReady;
    logic        memRead, memWrite, iord, irWrite, pcWrite;
    logic [1:0]  pcSrc;
    logic        regWrite, regSel, selDM, imSel, selFunc;
    logic [7:0]  funcCtrl;
    logic        illegal;
    logic [15:0] instCount;
    logic [2:0]  state;

    int nerr;
    int nchk;

    mc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
        .memReady  (memReady),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .iord      (iord),
        .irWrite   (irWrite),
        .pcWrite   (pcWrite),
        .pcSrc     (pcSrc),
        .regWrite  (regWrite),
        .regSel    (regSel),
        .selDM     (selDM),
        .imSel     (imSel),
        .selFunc   (selFunc),
        .funcCtrl  (funcCtrl),
        .illegal   (illegal),
        .instCount (instCount),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe bundle: {memRead,memWrite,iord,irWrite,pcWrite,pcSrc,regWrite,
    //                 regSel,selDM,imSel,selFunc,illegal}
    logic [12:0] strb;
    assign strb = {memRead, memWrite, iord, irWrite, pcWrite, pcSrc,
                   regWrite, regSel, selDM, imSel, selFunc, illegal};

    localparam logic [12:0] S_NONE = 13'h0000;
    localparam logic [12:0] S_MR   = 13'h1000;
    localparam logic [12:0] S_MW   = 13'h0800;
    localparam logic [12:0] S_IO   = 13'h0400;
    localparam logic [12:0] S_IR   = 13'h0200;
    localparam logic [12:0] S_PW   = 13'h0100;
    localparam logic [12:0] S_PSJ  = 13'h0080;
    localparam logic [12:0] S_PSB  = 13'h0040;
    localparam logic [12:0] S_RW   = 13'h0020;
    localparam logic [12:0] S_RS   = 13'h0010;
    localparam logic [12:0] S_DM   = 13'h0008;
    localparam logic [12:0] S_IM   = 13'h0004;
    localparam logic [12:0] S_SF   = 13'h0002;
    localparam logic [12:0] S_IL   = 13'h0001;

    localparam logic [7:0] F_ADD = 8'h02;
    localparam logic [7:0] F_SUB = 8'h04;
    localparam logic [7:0] F_NOP = 8'h40;

    localparam logic [3:0] LOAD    = 4'b0000;
    localparam logic [3:0] STORE   = 4'b0001;
    localparam logic [3:0] JUMP    = 4'b0010;
    localparam logic [3:0] BRANCHZ = 4'b0100;
    localparam logic [3:0] TYPEC   = 4'b1000;
    localparam logic [3:0] ADDI    = 4'b1100;

    localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2,
                           ST_M = 3'd3, ST_W = 3'd4, ST_I = 3'd5;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Let combinational outputs settle, then check state, strobes and ALU op.
    task automatic ex(input string tag, input logic [2:0] st, input logic [12:0] sb,
                      input logic [7:0] fc);
        #1;
        chk({tag, "_state"}, {13'd0, state}, {13'd0, st});
        chk({tag, "_strb"},  {3'd0, strb},   {3'd0, sb});
        chk({tag, "_func"},  {8'd0, funcCtrl}, {8'd0, fc});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nerr = 0;
        nchk = 0;
        rst = 1'b1;
        opcode = 4'b0000;
        zero = 1'b0;
        memReady = 1'b1;

        // Reset: everything quiet, state reads FETCH, count cleared.
        tick();
        tick();
        ex("rst", ST_F, S_NONE, F_NOP);
        chk("rst_cnt", instCount, 16'h0000);

        // ADDI, zero-wait: 0,1,2,4,0.
        rst = 1'b0; opcode = ADDI; memReady = 1'b1;
        ex("addi_f", ST_F, S_MR | S_IR | S_PW, F_NOP);
        tick(); ex("addi_d", ST_D, S_NONE, F_NOP);
        tick(); ex("addi_e", ST_E, S_IM, F_ADD);
        tick(); ex("addi_w", ST_W, S_RW | S_IM, F_ADD);
        chk("addi_cnt_w", instCount, 16'h0000);
        tick(); ex("addi_done", ST_F, S_MR | S_IR | S_PW, F_NOP);
        chk("addi_cnt", instCount, 16'h0001);

        // LOAD with two wait cycles in MEM: 7 cycles.
        opcode = LOAD;
        tick(); ex("ld_d", ST_D, S_NONE, F_NOP);
        tick(); ex("ld_e", ST_E, S_IM, F_ADD);
        tick(); memReady = 1'b0; ex("ld_m0", ST_M, S_MR | S_IO, F_NOP);
        tick(); ex("ld_m1", ST_M, S_MR | S_IO, F_NOP);
        tick(); memReady = 1'b1; ex("ld_m2", ST_M, S_MR | S_IO, F_NOP);
        tick(); memReady = 1'b0; ex("ld_w", ST_W, S_RW | S_DM, F_NOP);
        chk("ld_cnt_w", instCount, 16'h0001);
        tick(); memReady = 1'b1; ex("ld_done", ST_F, S_MR | S_IR | S_PW, F_NOP);
        chk("ld_cnt", instCount, 16'h0002);

        // BRANCHZ taken.
        opcode = BRANCHZ; zero = 1'b1;
        tick(); ex("bz1_d", ST_D, S_NONE, F_NOP);
        tick(); ex("bz1_e", ST_E, S_PW | S_PSB, F_SUB);
        tick(); ex("bz1_done", ST_F, S_MR | S_IR | S_PW, F_NOP);
        chk("bz1_cnt", instCount, 16'h0003);

        // BRANCHZ not taken.
        zero = 1'b0;
        tick(); ex("bz0_d", ST_D, S_NONE, F_NOP);
        tick(); ex("bz0_e", ST_E, S_NONE, F_SUB);
        tick(); ex("bz0_done", ST_F, S_MR | S_IR | S_PW, F_NOP);
        chk("bz0_cnt", instCount, 16'h0004);

        // TYPEC.
        opcode = TYPEC;
        tick(); ex("tc_d", ST_D, S_NONE, F_NOP);
        tick(); ex("tc_e", ST_E, S_SF, F_NOP);
        tick(); ex("tc_w", ST_W, S_RW | S_RS, F_NOP);
        tick(); ex("tc_done", ST_F, S_MR | S_IR | S_PW, F_NOP);
        chk("tc_cnt", instCount, 16'h0005);

        // STORE, zero-wait: 4 cycles.
        opcode = STORE;
        tick(); ex("st_d", ST_D, S_NONE, F_NOP);
        tick(); ex("st_e", ST_E, S_IM, F_ADD);
        tick(); ex("st_m", ST_M, S_MW | S_IO, F_NOP);
        tick(); memReady = 1'b0; ex("st_done", ST_F, S_MR, F_NOP);
        chk("st_cnt", instCount, 16'h0006);

        // FETCH wait, then JUMP.
        opcode = JUMP;
        tick(); ex("jf_wait", ST_F, S_MR, F_NOP);
        memReady = 1'b1; ex("jf_go", ST_F, S_MR | S_IR | S_PW, F_NOP);
        tick(); memReady = 1'b0; ex("j_d", ST_D, S_PW | S_PSJ, F_NOP);
        tick(); ex("j_done", ST_F, S_MR, F_NOP);
        chk("j_cnt", instCount, 16'h0007);

        // Undefined opcode 0011 parks in ILLEGAL.
        memReady = 1'b1; opcode = 4'b0011;
        tick(); ex("il_d", ST_D, S_NONE, F_NOP);
        for (int i = 0; i < 10; i++) begin
            tick();
            memReady = i[0];
            ex("il_hold", ST_I, S_IL, F_NOP);
        end
        chk("il_cnt", instCount, 16'h0007);
        rst = 1'b1;
        ex("il_rst", ST_F, S_NONE, F_NOP);
        tick(); rst = 1'b0; memReady = 1'b1; opcode = STORE;
        ex("il_after", ST_F, S_MR | S_IR | S_PW, F_NOP);
        chk("il_after_cnt", instCount, 16'h0000);

        // Reset during a STORE memory wait.
        tick(); ex("sr_d", ST_D, S_NONE, F_NOP);
        tick(); ex("sr_e", ST_E, S_IM, F_ADD);
        tick(); memReady = 1'b0; ex("sr_m0", ST_M, S_MW | S_IO, F_NOP);
        tick(); ex("sr_m1", ST_M, S_MW | S_IO, F_NOP);
        rst = 1'b1; ex("sr_rst", ST_F, S_NONE, F_NOP);
        tick(); rst = 1'b0; ex("sr_after", ST_F, S_MR, F_NOP);
        chk("sr_cnt", instCount, 16'h0000);

        // Counter wrap: 65535 JUMPs reach 0xFFFF, one more wraps to 0.
        opcode = JUMP; memReady = 1'b1;
        repeat (2 * 65535) @(posedge clk);
        #1;
        chk("wrap_pre_state", {13'd0, state}, {13'd0, ST_F});
        chk("wrap_pre", instCount, 16'hFFFF);
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_post", instCount, 16'h0000);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 opcode  in  4  instruction-register opcode; valid from DECODE onward.
REQ-004 zero  in  1  ALU zero flag.
REQ-005 memReady  in  1  shared instruction/data memory completes the current access this cycle.
REQ-006 memRead, memWrite  out  1 each  shared-memory read/write strobes.
REQ-007 iord  out  1  memory address select: 0 = PC, 1 = ALU result.
REQ-008 irWrite, pcWrite  out  1 each  instruction-register load; PC load.
REQ-009 pcSrc  out  2  PC source: 00 = PC+1, 01 = branch target, 10 = jump target.
REQ-010 regWrite, regSel, selDM, imSel, selFunc  out  1 each  register-file write; destination select (1 = TYPEC field); write data from memory; immediate operand; ALU function taken from the instruction.
REQ-011 funcCtrl  out  8  one-hot ALU op: ADD=00000010, SUB=00000100, AND=00001000, OR=00010000, NOP=01000000.
REQ-012 illegal  out  1  sticky undefined-opcode flag.
REQ-013 instCount  out  16  count of retired instructions.
REQ-014 state  out  3  current state, for debug.

Function
REQ-015 The block SHALL implement this FSM with these state encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ILLEGAL=5.
REQ-016 The outputs SHALL be decoded combinationally from state, opcode, zero and memReady. Any strobe not listed for a state SHALL be 0. funcCtrl SHALL be NOP unless a value is stated.
REQ-017 Opcodes SHALL be: LOAD=0000, STORE=0001, JUMP=0010, BRANCHZ=0100, TYPEC=1000, ADDI=1100, SUBI=1101, ANDI=1110, ORI=1111. All other opcodes are undefined.
REQ-018 FETCH: memRead=1 and iord=0.
  - memReady=0: stay in FETCH; no PC or IR update.
  - memReady=1: irWrite=1, pcWrite=1, pcSrc=00, next state DECODE.
REQ-019 DECODE, by opcode:
  - JUMP: pcWrite=1, pcSrc=10, instruction retires, next state FETCH.
  - Undefined opcode: next state ILLEGAL.
  - All other defined opcodes: next state EXEC.
REQ-020 EXEC, by opcode:
  - LOAD/STORE: funcCtrl=ADD, imSel=1, next state MEM.
  - ADDI/SUBI/ANDI/ORI: imSel=1, funcCtrl=ADD/SUB/AND/OR respectively, next state WB.
  - TYPEC: selFunc=1, next state WB.
  - BRANCHZ: funcCtrl=SUB; if zero=1 then pcWrite=1 and pcSrc=01; instruction retires; next state FETCH.
REQ-021 MEM: iord=1, with memRead=1 for LOAD or memWrite=1 for STORE.
  - memReady=0: hold the strobes and stay in MEM.
  - memReady=1, STORE: instruction retires, next state FETCH.
  - memReady=1, LOAD: next state WB.
REQ-022 WB: regWrite=1 for exactly one cycle, and the instruction retires.
  - LOAD: selDM=1.
  - TYPEC: regSel=1.
  - I-type: selDM=0, regSel=0, and the EXEC operand settings (imSel, funcCtrl) are held.
  - Next state FETCH.
REQ-023 ILLEGAL: illegal=1, all strobes 0, funcCtrl=NOP; the FSM stays in ILLEGAL until rst.
REQ-024 instCount SHALL increment by 1 on the clock edge that ends each retiring cycle named in REQ-019 to REQ-022, and SHALL wrap from 0xFFFF to 0x0000.
REQ-025 Cycle counts with zero-wait memory SHALL be:
  - JUMP: 2.
  - BRANCHZ: 3.
  - ALU and TYPEC: 4.
  - STORE: 4.
  - LOAD: 5.
  - Each cycle with memReady=0 in FETCH or MEM SHALL add one cycle.
REQ-026 memRead and memWrite SHALL never both be 1.
REQ-027 memReady SHALL be ignored outside FETCH and MEM.

Reset
REQ-028 While rst=1, all strobes, pcSrc and illegal SHALL be 0, funcCtrl SHALL be NOP, and state SHALL read FETCH.
REQ-029 On the first edge with rst=1, state SHALL load FETCH and instCount SHALL load 0, regardless of the current state, including mid-MEM wait and ILLEGAL.
REQ-030 Fetch SHALL start in the first cycle after rst falls.

Verification
REQ-031 ADDI (1100), memReady=1 -> states 0,1,2,4,0; funcCtrl=00000010 with imSel=1 in EXEC; regWrite pulse of 1 cycle; instCount 0->1.
REQ-032 LOAD with memReady low for 2 cycles in MEM -> 7 cycles total; memRead=1 and iord=1 held for 3 cycles; selDM=1 with regWrite=1 in WB.
REQ-033 BRANCHZ with zero=1, then zero=0 -> EXEC funcCtrl=00000100 in both. First case: pcWrite=1, pcSrc=01. Second case: pcWrite=0. Both take 3 cycles.
REQ-034 Opcode 0011 -> illegal=1 from cycle 3 onward, all strobes 0 for 10 cycles; rst=1 for one cycle -> state 0, illegal=0, instCount=0.
REQ-035 rst asserted during a MEM wait on a STORE -> memWrite=0 in the same cycle; FETCH after release; instCount unchanged from 0.
REQ-036 Preload instCount=0xFFFF with 65535 JUMPs, then one more JUMP -> instCount=0x0000.
